// File: rtl/mouse_viewport_tracker_pkg.sv
// Shared constants and the saturating coordinate update for the mouse
// viewport tracker. Package name: mouse_view_pkg.
package mouse_view_pkg;

  localparam int POS_W  = 14;
  localparam int H_MAX  = 6400;
  localparam int V_MAX  = 4800;
  localparam int H_INIT = 3200;
  localparam int V_INIT = 2400;

  // Adds a signed delta to an unsigned coordinate with two guard bits,
  // clamping the result into 0..max.
  function automatic logic [POS_W-1:0] sat_add(
    input logic        [POS_W-1:0] pos,
    input logic signed [POS_W+1:0] delta,
    input logic        [POS_W-1:0] max
  );
    logic signed [POS_W+1:0] sum;
    sum = $signed({2'b00, pos}) + delta;
    if (sum < 0)
      sat_add = '0;
    else if (sum > $signed({2'b00, max}))
      sat_add = max;
    else
      sat_add = sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/mouse_viewport_tracker_axis_accum.sv
// One axis of the viewport tracker: scales and orients a 9-bit packet delta
// (stage 1), then applies it to the coordinate with clamping (stage 2).
// Recenter returns the coordinate to INIT and discards in-flight deltas.
// Optional build macro ACCEL_EN doubles the gain for large deltas.
module axis_accum #(
  parameter int POS_W      = mouse_view_pkg::POS_W,
  parameter int MAX        = mouse_view_pkg::H_MAX,
  parameter int INIT       = mouse_view_pkg::H_INIT,
  parameter bit INVERT     = 1'b0,
  parameter int GAIN_SHIFT = 1
`ifdef ACCEL_EN
  , parameter int ACCEL_TH = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    recenter,
  input  logic                    tick,
  input  logic signed [8:0]       delta,
  output logic        [POS_W-1:0] pos
);
  import mouse_view_pkg::*;

  localparam int DW = POS_W + 2;

  logic signed [DW-1:0] ext;
  logic signed [DW-1:0] scaled;
  logic signed [DW-1:0] d_nxt;
  logic signed [DW-1:0] d_p1;
  logic                 vld_p1;
`ifdef ACCEL_EN
  logic signed [DW-1:0] mag;
`endif

  // Sign-extend, apply gain, and flip orientation when INVERT is set
  always_comb begin
    ext = DW'(delta);
`ifdef ACCEL_EN
    mag = (ext < 0) ? -ext : ext;
    if (mag >= DW'(ACCEL_TH))
      scaled = ext <<< (GAIN_SHIFT + 1);
    else
      scaled = ext <<< GAIN_SHIFT;
`else
    scaled = ext <<< GAIN_SHIFT;
`endif
    d_nxt = INVERT ? -scaled : scaled;
  end

  // ---- stage 0 -> stage 1: delta register (qualified by vld_p1)
  always_ff @(posedge clk) d_p1 <= d_nxt;

  // ---- stage 1 -> stage 2: saturating update; recenter overrides the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      pos    <= POS_W'(INIT);
    end else if (recenter) begin
      vld_p1 <= 1'b0;
      pos    <= POS_W'(INIT);
    end else begin
      vld_p1 <= tick;
      if (vld_p1)
        pos <= sat_add(pos, d_p1, POS_W'(MAX));
    end
  end

endmodule

// File: rtl/mouse_viewport_tracker.sv
// Mouse viewport tracker: turns PS/2 mouse packets into clamped viewport
// coordinates, a per-packet update strobe and button press pulses.
// Optional build macro ACCEL_EN enables large-delta acceleration.
module mouse_viewport_tracker #(
  parameter int POS_W      = mouse_view_pkg::POS_W,
  parameter int H_MAX      = mouse_view_pkg::H_MAX,
  parameter int V_MAX      = mouse_view_pkg::V_MAX,
  parameter int H_INIT     = mouse_view_pkg::H_INIT,
  parameter int V_INIT     = mouse_view_pkg::V_INIT,
  parameter int GAIN_SHIFT = 1
`ifdef ACCEL_EN
  , parameter int ACCEL_TH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       xm,
  input  logic [8:0]       ym,
  input  logic [2:0]       btnm,
  input  logic             m_done_tick,
  input  logic             recenter,
  output logic [POS_W-1:0] h_position,
  output logic [POS_W-1:0] v_position,
  output logic             pos_valid,
  output logic [2:0]       click_pulse
);
  import mouse_view_pkg::*;

  logic       vld_p1;
  logic [2:0] btn_prev;
  logic [2:0] press_p1;

  axis_accum #(
    .POS_W(POS_W), .MAX(H_MAX), .INIT(H_INIT), .INVERT(1'b0), .GAIN_SHIFT(GAIN_SHIFT)
`ifdef ACCEL_EN
    , .ACCEL_TH(ACCEL_TH)
`endif
  ) u_h_axis (
    .clk(clk), .rst(rst), .recenter(recenter), .tick(m_done_tick),
    .delta($signed(xm)), .pos(h_position)
  );

  // PS/2 Y is positive-up; the screen is positive-down, so the Y axis inverts
  axis_accum #(
    .POS_W(POS_W), .MAX(V_MAX), .INIT(V_INIT), .INVERT(1'b1), .GAIN_SHIFT(GAIN_SHIFT)
`ifdef ACCEL_EN
    , .ACCEL_TH(ACCEL_TH)
`endif
  ) u_v_axis (
    .clk(clk), .rst(rst), .recenter(recenter), .tick(m_done_tick),
    .delta($signed(ym)), .pos(v_position)
  );

  // ---- stage 0 -> stage 1: press edges relative to the previous packet
  always_ff @(posedge clk) press_p1 <= btnm & ~btn_prev;

  // ---- stage 1 -> stage 2: valid tracking, button history and output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      btn_prev    <= 3'b000;
      pos_valid   <= 1'b0;
      click_pulse <= 3'b000;
    end else begin
      if (m_done_tick)
        btn_prev <= btnm;
      vld_p1      <= m_done_tick & ~recenter;
      pos_valid   <= vld_p1 & ~recenter;
      click_pulse <= (vld_p1 && !recenter) ? press_p1 : 3'b000;
    end
  end

endmodule
